// File: rtl/prt_fald_lpb.sv
// FALD LED pixel buffer: packs 4-bit nibbles into pixels, queues them in a RAM FIFO, streams them out valid/ready.
// Latency: last nibble to PIX_VLD_OUT is 3 clocks; a stalled sink holds PIX_DAT_OUT and pixels completing while full are dropped.
module prt_fald_lpb #(
    parameter string P_VENDOR    = "none",
    parameter int    P_PIX_WIDTH = 24,
    parameter int    P_DEPTH     = 256
) (
    input  logic                   CLK_IN,
    input  logic                   RST_IN,
    input  logic [3:0]             LPB_DAT_IN,
    input  logic                   LPB_VLD_IN,
    input  logic                   CLR_IN,
    output logic [P_PIX_WIDTH-1:0] PIX_DAT_OUT,
    output logic                   PIX_VLD_OUT,
    input  logic                   PIX_RDY_IN,
    output logic [31:0]            STA_OUT
);

    localparam int NIB = P_PIX_WIDTH / 4;
    localparam int AW  = $clog2(P_DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

    logic [3:0]             nib_cnt;
    logic [P_PIX_WIDTH-1:0] asm_q;
    logic [P_PIX_WIDTH-1:0] asm_nxt;
    logic [P_PIX_WIDTH-1:0] wr_dat;
    logic                   wr_stb;
    logic [AW:0]            wptr;
    logic [AW:0]            wptr_d;
    logic [AW:0]            rptr;
    logic [AW:0]            fill;
    logic                   ovf;
    logic                   full;
    logic                   empty;
    logic                   rd_empty;
    logic                   out_free;
    logic                   rd_en;
    logic                   wr_en;
    logic                   last_nib;
    logic [P_PIX_WIDTH-1:0] ram_rd;
    logic [P_PIX_WIDTH-1:0] mem [P_DEPTH];

    always_comb begin
        asm_nxt = asm_q;
        for (int k = 0; k < NIB; k++) begin
            if (nib_cnt == 4'(k)) begin
                asm_nxt[4*k +: 4] = LPB_DAT_IN;
            end
        end
    end

    assign last_nib = (nib_cnt == 4'(NIB - 1));
    assign full     = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign empty    = (wptr == rptr);
    // The read side sees writes one cycle late, so a slot is never read in the cycle it is written.
    assign rd_empty = (wptr_d == rptr);
    assign out_free = !PIX_VLD_OUT || PIX_RDY_IN;
    assign rd_en    = !rd_empty && out_free && !CLR_IN;
    assign wr_en    = wr_stb && !full && !CLR_IN;
    assign fill     = wptr - rptr;
    assign ram_rd   = mem[rptr[AW-1:0]];
    assign STA_OUT  = {8'd0, nib_cnt, 1'b0, full, empty, ovf, 16'(fill)};

    generate
        if (P_VENDOR == "none") begin : g_ram_inferred
            always_ff @(posedge CLK_IN) begin
                if (wr_en) mem[wptr[AW-1:0]] <= wr_dat;
            end
        end else begin : g_ram_vendor
            // Vendor primitives slot in here; the plain array maps well on current targets.
            always_ff @(posedge CLK_IN) begin
                if (wr_en) mem[wptr[AW-1:0]] <= wr_dat;
            end
        end
    endgenerate

    always_ff @(posedge CLK_IN or posedge RST_IN) begin
        if (RST_IN) begin
            nib_cnt     <= '0;
            asm_q       <= '0;
            wr_dat      <= '0;
            wr_stb      <= 1'b0;
            wptr        <= '0;
            wptr_d      <= '0;
            rptr        <= '0;
            ovf         <= 1'b0;
            PIX_DAT_OUT <= '0;
            PIX_VLD_OUT <= 1'b0;
        end else if (CLR_IN) begin
            nib_cnt     <= '0;
            asm_q       <= '0;
            wr_stb      <= 1'b0;
            wptr        <= '0;
            wptr_d      <= '0;
            rptr        <= '0;
            ovf         <= 1'b0;
            PIX_VLD_OUT <= 1'b0;
        end else begin
            wr_stb <= 1'b0;
            if (LPB_VLD_IN) begin
                asm_q <= asm_nxt;
                if (last_nib) begin
                    nib_cnt <= '0;
                    wr_stb  <= 1'b1;
                    wr_dat  <= asm_nxt;
                end else begin
                    nib_cnt <= nib_cnt + 4'd1;
                end
            end

            if (wr_stb) begin
                if (full) ovf  <= 1'b1;
                else      wptr <= wptr + PTR_ONE;
            end
            wptr_d <= wptr;

            if (rd_en) begin
                rptr        <= rptr + PTR_ONE;
                PIX_DAT_OUT <= ram_rd;
                PIX_VLD_OUT <= 1'b1;
            end else if (PIX_RDY_IN) begin
                PIX_VLD_OUT <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_prt_fald_lpb.sv
// Directed bench for prt_fald_lpb at 24-bit pixels, depth 256.
module tb_prt_fald_lpb;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  lpb_dat = '0;
    logic        lpb_vld = 1'b0;
    logic        clr = 1'b0;
    logic [23:0] pix_dat;
    logic        pix_vld;
    logic        pix_rdy = 1'b0;
    logic [31:0] sta;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    prt_fald_lpb #(
        .P_VENDOR    ("none"),
        .P_PIX_WIDTH (24),
        .P_DEPTH     (256)
    ) dut (
        .CLK_IN      (clk),
        .RST_IN      (rst),
        .LPB_DAT_IN  (lpb_dat),
        .LPB_VLD_IN  (lpb_vld),
        .CLR_IN      (clr),
        .PIX_DAT_OUT (pix_dat),
        .PIX_VLD_OUT (pix_vld),
        .PIX_RDY_IN  (pix_rdy),
        .STA_OUT     (sta)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_nib(input logic [3:0] d);
        lpb_dat = d;
        lpb_vld = 1'b1;
        tick();
        lpb_vld = 1'b0;
    endtask

    task automatic send_pix(input logic [23:0] v);
        for (int k = 0; k < 6; k++) send_nib(v[4*k +: 4]);
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        #2;
        n_cmp++;
        if (pix_vld !== 1'b0 || pix_dat !== 24'h0 || sta !== 32'h0002_0000) begin
            n_err++;
            $display("FAIL reset_hold: vld=%b dat=%h sta=%h, want vld=0 dat=000000 sta=00020000", pix_vld, pix_dat, sta);
        end
        #19 rst = 1'b0;
        tick();
        n_cmp++;
        if (pix_vld !== 1'b0 || sta !== 32'h0002_0000) begin
            n_err++;
            $display("FAIL reset_release: vld=%b sta=%h, want vld=0 sta=00020000", pix_vld, sta);
        end
    endtask

    task automatic test_latency();
        pix_rdy = 1'b1;
        for (int d = 1; d <= 6; d++) send_nib(4'(d));
        n_cmp++;
        if (pix_vld !== 1'b0) begin n_err++; $display("FAIL lat_e0_vld: got %b want 0", pix_vld); end
        tick();
        n_cmp++;
        if (sta !== 32'h0000_0001) begin n_err++; $display("FAIL lat_e1_sta: got %h want 00000001", sta); end
        tick();
        n_cmp++;
        if (pix_vld !== 1'b0) begin n_err++; $display("FAIL lat_e2_vld: got %b want 0", pix_vld); end
        tick();
        n_cmp++;
        if (pix_vld !== 1'b1 || pix_dat !== 24'h654321) begin
            n_err++;
            $display("FAIL lat_e3_pix: vld=%b dat=%h, want vld=1 dat=654321", pix_vld, pix_dat);
        end
        tick();
        n_cmp++;
        if (pix_vld !== 1'b0 || sta !== 32'h0002_0000) begin
            n_err++;
            $display("FAIL lat_e4_idle: vld=%b sta=%h, want vld=0 sta=00020000", pix_vld, sta);
        end
    endtask

    task automatic test_overflow();
        pix_rdy = 1'b0;
        for (int i = 0; i < 256; i++) send_pix(24'(i));
        repeat (4) tick();
        n_cmp++;
        if (sta !== 32'h0000_00FF || pix_vld !== 1'b1 || pix_dat !== 24'h0) begin
            n_err++;
            $display("FAIL ovf_255: sta=%h vld=%b dat=%h, want sta=000000ff vld=1 dat=000000", sta, pix_vld, pix_dat);
        end
        send_pix(24'd256);
        repeat (2) tick();
        n_cmp++;
        if (sta !== 32'h0004_0100) begin n_err++; $display("FAIL ovf_full: got %h want 00040100", sta); end
        send_pix(24'hABCDEF);
        repeat (2) tick();
        n_cmp++;
        if (sta !== 32'h0005_0100) begin n_err++; $display("FAIL ovf_drop: got %h want 00050100", sta); end
    endtask

    task automatic test_drain();
        int bad = 0;
        pix_rdy = 1'b1;
        for (int i = 0; i <= 256; i++) begin
            n_cmp++;
            if (pix_vld !== 1'b1 || pix_dat !== 24'(i)) begin
                n_err++;
                bad++;
                if (bad < 5) $display("FAIL drain_seq[%0d]: vld=%b dat=%h, want vld=1 dat=%h", i, pix_vld, pix_dat, 24'(i));
            end
            tick();
        end
        n_cmp++;
        if (pix_vld !== 1'b0 || sta !== 32'h0003_0000) begin
            n_err++;
            $display("FAIL drain_end: vld=%b sta=%h, want vld=0 sta=00030000", pix_vld, sta);
        end
    endtask

    task automatic test_clear();
        int          seen = 0;
        logic [23:0] got = '0;
        pix_rdy = 1'b1;
        send_nib(4'h1);
        send_nib(4'h2);
        send_nib(4'h3);
        n_cmp++;
        if (sta !== 32'h0033_0000) begin n_err++; $display("FAIL clr_pre: got %h want 00330000", sta); end
        clr = 1'b1;
        lpb_dat = 4'h4;
        lpb_vld = 1'b1;
        tick();
        clr = 1'b0;
        lpb_vld = 1'b0;
        n_cmp++;
        if (sta !== 32'h0002_0000 || pix_vld !== 1'b0) begin
            n_err++;
            $display("FAIL clr_post: sta=%h vld=%b, want sta=00020000 vld=0", sta, pix_vld);
        end
        for (int d = 10; d <= 15; d++) send_nib(4'(d));
        for (int c = 0; c < 8; c++) begin
            if (pix_vld === 1'b1) begin
                seen++;
                got = pix_dat;
            end
            tick();
        end
        n_cmp++;
        if (seen !== 1 || got !== 24'hFEDCBA) begin
            n_err++;
            $display("FAIL clr_pixel: count=%0d dat=%h, want count=1 dat=fedcba", seen, got);
        end
        n_cmp++;
        if (sta !== 32'h0002_0000) begin n_err++; $display("FAIL clr_sta: got %h want 00020000", sta); end
    endtask

    task automatic test_back_to_back();
        logic [23:0] exp_q[$];
        int          got_n = 0;
        int          cycles = 0;
        bit          prev_stall = 1'b0;
        logic [23:0] prev_dat = '0;
        logic [23:0] e;
        fork
            begin
                for (int p = 0; p < 1000; p++) begin
                    logic [23:0] v;
                    v = 24'($urandom);
                    for (int k = 0; k < 6; k++) begin
                        if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) tick();
                        if (k == 5) exp_q.push_back(v);
                        send_nib(v[4*k +: 4]);
                    end
                end
            end
            begin
                while (got_n < 1000 && cycles < 40000) begin
                    if (prev_stall) begin
                        n_cmp++;
                        if (pix_vld !== 1'b1 || pix_dat !== prev_dat) begin
                            n_err++;
                            $display("FAIL bp_stable: vld=%b dat=%h, want vld=1 dat=%h", pix_vld, pix_dat, prev_dat);
                        end
                    end
                    pix_rdy = ($urandom_range(0, 2) != 0);
                    if (pix_vld === 1'b1 && pix_rdy) begin
                        n_cmp++;
                        if (exp_q.size() == 0) begin
                            n_err++;
                            $display("FAIL bp_order: got %h want nothing (no pixel pending)", pix_dat);
                        end else begin
                            e = exp_q.pop_front();
                            if (pix_dat !== e) begin
                                n_err++;
                                $display("FAIL bp_order[%0d]: got %h want %h", got_n, pix_dat, e);
                            end
                        end
                        got_n++;
                    end
                    prev_stall = (pix_vld === 1'b1) && !pix_rdy;
                    prev_dat = pix_dat;
                    tick();
                    cycles++;
                end
                n_cmp++;
                if (got_n < 1000) begin
                    n_err++;
                    $display("FAIL bp_timeout: got %0d pixels want 1000", got_n);
                end
            end
        join
    endtask

    task automatic test_async_reset();
        pix_rdy = 1'b0;
        tick();
        for (int i = 0; i < 6; i++) send_pix(24'h000100 + 24'(i));
        repeat (3) tick();
        n_cmp++;
        if (sta !== 32'h0000_0005) begin n_err++; $display("FAIL arst_pre_fill: got %h want 00000005", sta); end
        send_nib(4'h7);
        send_nib(4'h8);
        send_nib(4'h9);
        n_cmp++;
        if (sta !== 32'h0030_0005) begin n_err++; $display("FAIL arst_pre_nib: got %h want 00300005", sta); end
        #3 rst = 1'b1;
        #1;
        n_cmp++;
        if (pix_vld !== 1'b0 || pix_dat !== 24'h0 || sta !== 32'h0002_0000) begin
            n_err++;
            $display("FAIL arst_now: vld=%b dat=%h sta=%h, want vld=0 dat=000000 sta=00020000", pix_vld, pix_dat, sta);
        end
        #2 rst = 1'b0;
        tick();
        pix_rdy = 1'b1;
        send_pix(24'h13579B);
        tick();
        tick();
        n_cmp++;
        if (pix_vld !== 1'b0) begin n_err++; $display("FAIL arst_e2_vld: got %b want 0", pix_vld); end
        tick();
        n_cmp++;
        if (pix_vld !== 1'b1 || pix_dat !== 24'h13579B) begin
            n_err++;
            $display("FAIL arst_pixel: vld=%b dat=%h, want vld=1 dat=13579b", pix_vld, pix_dat);
        end
        tick();
        n_cmp++;
        if (pix_vld !== 1'b0 || sta !== 32'h0002_0000) begin
            n_err++;
            $display("FAIL arst_idle: vld=%b sta=%h, want vld=0 sta=00020000", pix_vld, sta);
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_overflow();
        test_drain();
        test_clear();
        test_back_to_back();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/prt_fald_lpb.md
# prt_fald_lpb

LED pixel buffer for the FALD (full-array local dimming) path. Receives the 4-bit nibble write stream produced by the FALD control block's LED pixel buffer port and assembles nibbles into pixel words. Pixels are stored in a RAM-backed FIFO and presented on a valid/ready pixel stream to the LED driver side. Fill and error status is exported as a 32-bit word suitable for an FALD control ingress port.

## Interface

Parameters:
- P_VENDOR, "none", vendor selector for RAM inference.
- P_PIX_WIDTH, 24, pixel width in bits; multiple of 4, range 4..32.
- P_DEPTH, 256, FIFO depth in pixels; power of 2, range 4..32768.

Ports:
- CLK_IN  input  1  single clock.
- RST_IN  input  1  reset; asynchronous, active-high.
- LPB_DAT_IN  input  4  nibble data.
- LPB_VLD_IN  input  1  nibble valid, one nibble per high cycle.
- CLR_IN  input  1  synchronous clear pulse.
- PIX_DAT_OUT  output  P_PIX_WIDTH  pixel data.
- PIX_VLD_OUT  output  1  pixel valid.
- PIX_RDY_IN  input  1  pixel ready from sink.
- STA_OUT  output  32  status word.

## Operation

- N = P_PIX_WIDTH/4 nibbles per pixel.
- The nibble counter runs 0..N-1. Nibble k is written to assembly bits [4k+3:4k], LSB nibble first.
- On the Nth nibble, the counter wraps to 0 and a write strobe is raised for exactly one cycle.
- FIFO write:
  - Registered; uses read/write pointers of log2(P_DEPTH)+1 bits.
  - full = pointers equal except MSB; empty = pointers equal.
  - Full is evaluated before any same-cycle read. A pixel completing while full is dropped, even if a read happens that cycle, and the overflow flag is set.
- Output stage:
  - One output register with a 1-cycle-latency RAM read.
  - A RAM read is issued when the FIFO is non-empty and either the output register is empty or it is being consumed (PIX_VLD_OUT & PIX_RDY_IN). At most one read is in flight.
  - The stage sustains 1 pixel/cycle throughput when the sink is always ready.
- Transfer occurs on a cycle with PIX_VLD_OUT & PIX_RDY_IN.
- PIX_DAT_OUT holds stable while PIX_VLD_OUT=1 and PIX_RDY_IN=0.
- CLR_IN clears pointers, nibble counter, partial pixel, in-flight read, output valid, and the overflow flag in one cycle.
- CLR_IN has priority over a same-cycle nibble, write, or read; that nibble is discarded.
- STA_OUT fields:
  - [15:0] fill level = entries in the RAM, excluding the output register.
  - [16] overflow, sticky.
  - [17] empty.
  - [18] full.
  - [23:20] nibble counter.
  - other bits 0.

## Timing

- Reset values:
  - PIX_DAT_OUT=0, PIX_VLD_OUT=0, STA_OUT=0x0002_0000 (empty only).
  - Counters, pointers, and flags are all 0.
- Latency into an empty block with PIX_RDY_IN=1 (edges numbered from the last nibble):
  - Last nibble sampled at edge E0.
  - RAM written and fill level incremented at E1.
  - RAM read issued at E2.
  - PIX_VLD_OUT=1 after E3, so 3 clocks from the last nibble edge.
- Fill level updates on the edge of the write or read: +1 on write, -1 on read, unchanged if both happen in the same cycle.
- Nibbles may arrive on consecutive cycles or with arbitrary gaps. Gaps do not reset the counter; only CLR_IN or RST_IN do.
- RST_IN asserted mid-pixel or mid-read: everything returns asynchronously to its reset values, and the partial pixel is lost.
- Pointer wrap-around at P_DEPTH uses natural modulo in the extra-MSB scheme and needs no special case.
- The overflow flag clears only on CLR_IN or RST_IN.

## Test plan

- Reset, then nibbles 0x1..0x6 on consecutive cycles with PIX_RDY_IN=1 (P_PIX_WIDTH=24) -> PIX_DAT_OUT=0x654321, PIX_VLD_OUT high for 1 cycle, 3 clocks after the 6th nibble edge; STA_OUT returns to 0x0002_0000.
- PIX_RDY_IN=0; write 256 pixels (values 0..255), then 1 more (P_DEPTH=256) -> after the first pixel moves to the output register, 255 are in RAM. The 257th pixel fills RAM: STA_OUT[15:0]=256, full=1, overflow=0. The 258th pixel is dropped and sets STA_OUT[16]=1.
- From full, set PIX_RDY_IN=1 -> pixels stream out in order 0..256 with no gaps (PIX_VLD_OUT continuously high), and the dropped value never appears. Afterwards empty=1 and overflow stays 1.
- 3 nibbles, then CLR_IN together with a 4th nibble, then 6 nibbles 0xA..0xF -> STA_OUT[23:20]=0 after the clear; the only output pixel is 0xFEDCBA; overflow is cleared.
- Backpressure: PIX_RDY_IN toggled pseudo-randomly over 1000 random pixels with random nibble gaps -> the output sequence equals the input sequence, and PIX_DAT_OUT stays stable while stalled.
- Assert RST_IN asynchronously (not aligned to an edge) in the middle of a pixel with the FIFO holding 5 entries -> PIX_VLD_OUT=0 and STA_OUT=0x0002_0000 immediately. A following full pixel then emerges correctly.
